// File: rtl/load_store_unit_pkg.sv
// Shared encodings and request-decoding helpers for the RV32I load/store unit.
// Covers FSM states, fault causes, funct3 codes and byte-lane/store-data shaping.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } fault_cause_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3[1:0])
      2'd0:    lanes = {4{wd[7:0]}};
      2'd1:    lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/grant/response bus between the load/store unit (master)
// and the memory subsystem (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Shifts the addressed bytes of a memory word down to bit 0 and sign- or
// zero-extends them according to the load funct3 code.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_ext;
  logic signed [31:0] half_ext;

  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    byte_s   = shifted[7:0];
    half_s   = shifted[15:0];
    byte_ext = byte_s;
    half_ext = half_s;
    case (funct3)
      F3_B:    data = byte_ext;
      F3_H:    data = half_ext;
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request from execute, checks funct3 and
// alignment, runs a single memory transaction with a timeout, returns a response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [4:0]        rd_in,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [4:0]        rd_out,
  output logic              fault,
  output logic [1:0]        fault_cause,
  load_store_unit_if.master mem
);

  localparam int               CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fault_cause_e     cause_q, cause_d;

  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;

  logic [31:0]      load_data;
  logic             accept;
  logic             expire;
  logic             in_req;
  logic             in_resp;

  load_align u_load_align (
    .rdata  (mem.mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  assign req_ready = (state_q == ST_IDLE) && rst;
  assign accept    = req_valid && req_ready;
  // Last cycle of the REQ+WAIT budget; a completion in this cycle still wins.
  assign expire    = (cnt_q == CNT_LAST);
  assign in_req    = (state_q == ST_REQ);
  assign in_resp   = (state_q == ST_RESP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr;
          wdata_d    = wdata;
          rd_d       = rd_in;
          data_d     = '0;
          cnt_d      = '0;
          if (!f3_legal(is_store, funct3)) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = ST_RESP;
          end else if (f3_misaligned(funct3, addr[1:0])) begin
            cause_d = CAUSE_MISALIGN;
            state_d = ST_RESP;
          end else begin
            cause_d = CAUSE_NONE;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.mem_gnt && is_store_q) begin
          state_d = ST_RESP;
        end else if (mem.mem_gnt && mem.mem_rvalid) begin
          data_d  = load_data;
          state_d = ST_RESP;
        end else if (expire) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_RESP;
        end else if (mem.mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.mem_rvalid) begin
          data_d  = load_data;
          state_d = ST_RESP;
        end else if (expire) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state: asynchronously cleared so an in-flight transaction is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Captured request and load result; every output use is qualified by state.
  always_ff @(posedge clk) begin
    is_store_q <= is_store_d;
    funct3_q   <= funct3_d;
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    rd_q       <= rd_d;
    data_q     <= data_d;
  end

  always_comb begin
    mem.mem_req   = in_req;
    mem.mem_we    = in_req && is_store_q;
    mem.mem_be    = in_req ? byte_enable(funct3_q, addr_q[1:0]) : 4'b0000;
    mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem.mem_wdata = (in_req && is_store_q) ? store_lanes(funct3_q, wdata_q) : 32'd0;
  end

  always_comb begin
    resp_valid  = in_resp;
    resp_data   = in_resp ? data_q : 32'd0;
    rd_out      = in_resp ? rd_q : 5'd0;
    fault       = in_resp && (cause_q != CAUSE_NONE);
    fault_cause = in_resp ? cause_q : CAUSE_NONE;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus random
// requests against a byte-level reference model with a scripted memory.
module tb_load_store_unit;

  localparam int MAX_WAIT = 15;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_in;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  rd_out;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit_if mem_bus ();

  load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .rd_in       (rd_in),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .rd_out      (rd_out),
    .fault       (fault),
    .fault_cause (fault_cause),
    .mem         (mem_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: the transaction outcome derived from access size, byte lanes and
  // the cycle on which the scripted memory grants / returns data.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdv, input int g, input int d,
                       output logic [1:0] cause, output logic [31:0] data, output int lat,
                       output int nreq, output logic [3:0] be, output logic [31:0] mwd);
    int  size;
    int  off;
    int  done_idx;
    bit  legal;
    bit  sgn;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(a[1:0]);
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sgn   = (f3 == 3'd0) || (f3 == 3'd1);
    be    = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size);
    mwd   = (size == 1) ? {wd[7:0], wd[7:0], wd[7:0], wd[7:0]} :
            (size == 2) ? {wd[15:0], wd[15:0]} : wd;
    data  = '0;
    if (!legal) begin
      cause = 2'b11; lat = 1; nreq = 0;
    end else if ((off % size) != 0) begin
      cause = 2'b01; lat = 1; nreq = 0;
    end else begin
      done_idx = st ? g : g + d;
      nreq     = (g < MAX_WAIT) ? g + 1 : MAX_WAIT;
      if (done_idx < MAX_WAIT) begin
        cause = 2'b00;
        lat   = done_idx + 2;
        if (!st) begin
          v = '0;
          for (int i = 0; i < size; i++) v[8*i +: 8] = rdv[8*(off+i) +: 8];
          if (sgn && v[8*size-1]) for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
          data = v;
        end
      end else begin
        cause = 2'b10;
        lat   = MAX_WAIT + 1;
      end
    end
  endtask

  // g: REQ cycle (0-based) carrying mem_gnt; d: cycles from gnt to rvalid.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdv, input logic [4:0] rd,
                         input int g, input int d);
    logic [1:0]  e_cause;
    logic [31:0] e_data;
    int          e_lat;
    int          e_nreq;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    bit          seen;
    bit          stable;
    int          lat;
    int          nreq;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [3:0]  r_be;
    logic        r_we;
    logic [31:0] g_data;
    logic [1:0]  g_cause;
    logic        g_fault;
    logic [4:0]  g_rd;
    model(st, f3, a, wd, rdv, g, d, e_cause, e_data, e_lat, e_nreq, e_be, e_wd);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; rd_in = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom; rd_in = 5'($urandom);
    seen = 0; stable = 1; lat = 0; nreq = 0;
    r_addr = '0; r_wd = '0; r_be = '0; r_we = 1'b0;
    g_data = '0; g_cause = '0; g_fault = 1'b0; g_rd = '0;
    for (int k = 1; k <= MAX_WAIT + 4 && !seen; k++) begin
      if (resp_valid) begin
        seen = 1; lat = k;
        g_data = resp_data; g_cause = fault_cause; g_fault = fault; g_rd = rd_out;
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'($urandom);
        mem_bus.mem_rdata  = $urandom;
        @(negedge clk);
      end else begin
        if (mem_bus.mem_req) begin
          if (nreq == 0) begin
            r_addr = mem_bus.mem_addr; r_wd = mem_bus.mem_wdata;
            r_be = mem_bus.mem_be; r_we = mem_bus.mem_we;
          end else if (r_addr !== mem_bus.mem_addr || r_wd !== mem_bus.mem_wdata ||
                       r_be !== mem_bus.mem_be || r_we !== mem_bus.mem_we) begin
            stable = 0;
          end
          nreq++;
        end
        mem_bus.mem_gnt    = (k == g + 1);
        mem_bus.mem_rvalid = (!st && k == g + 1 + d) || (k <= g && $urandom_range(0, 1) == 1);
        mem_bus.mem_rdata  = (k == g + 1 + d) ? rdv : $urandom;
        @(negedge clk);
      end
    end
    if (!seen) begin
      chk("resp_seen", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(lat), 32'(e_lat));
      chk("resp_data", g_data, e_data);
      chk("fault_cause", 32'(g_cause), 32'(e_cause));
      chk("fault", 32'(g_fault), 32'(e_cause != 2'b00));
      chk("rd_out", 32'(g_rd), 32'(rd));
      chk("mem_req_cycles", 32'(nreq), 32'(e_nreq));
      if (e_nreq > 0) begin
        chk("mem_addr", r_addr, {a[31:2], 2'b00});
        chk("mem_be", 32'(r_be), 32'(e_be));
        chk("mem_we", 32'(r_we), 32'(st));
        chk("mem_wdata", r_wd, st ? e_wd : 32'd0);
        chk("req_stable", 32'(stable), 32'd1);
      end
      chk("resp_one_cycle", 32'(resp_valid), 32'd0);
      chk("ready_after", 32'(req_ready), 32'd1);
    end
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
  endtask

  task automatic launch_load(input logic [31:0] a);
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = a; wdata = '0; rd_in = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; rd_in = '0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_release_ready", 32'(req_ready), 32'd1);

    run_txn(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 5'd1, 0, 1);
    run_txn(1'b0, 3'd0, 32'h103, 32'd0, 32'h80112233, 5'd2, 0, 1);
    run_txn(1'b0, 3'd4, 32'h103, 32'd0, 32'h80112233, 5'd3, 0, 1);
    run_txn(1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'd0, 5'd4, 0, 0);
    run_txn(1'b0, 3'd2, 32'h101, 32'd0, 32'd0, 5'd5, 0, 1);
    run_txn(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 5'd6, 0, 1);
    run_txn(1'b0, 3'd3, 32'h101, 32'd0, 32'd0, 5'd7, 0, 1);
    run_txn(1'b1, 3'd4, 32'h100, 32'h1234, 32'd0, 5'd8, 0, 0);
    run_txn(1'b0, 3'd2, 32'h100, 32'd0, 32'h11111111, 5'd9, 100, 0);
    run_txn(1'b0, 3'd1, 32'h102, 32'd0, 32'h9ABC0000, 5'd10, 0, 0);
    run_txn(1'b0, 3'd5, 32'h102, 32'd0, 32'h9ABC0000, 5'd11, MAX_WAIT - 1, 0);
    run_txn(1'b0, 3'd2, 32'h104, 32'd0, 32'h55AA55AA, 5'd12, 2, MAX_WAIT - 3);
    run_txn(1'b0, 3'd2, 32'h104, 32'd0, 32'h55AA55AA, 5'd13, 2, MAX_WAIT - 2);
    run_txn(1'b1, 3'd0, 32'h301, 32'h000000C3, 32'd0, 5'd14, MAX_WAIT - 1, 0);
    run_txn(1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'd0, 5'd15, MAX_WAIT, 0);

    // Reset while waiting for read data: abandoned, late rvalid ignored.
    launch_load(32'h400);
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstwait_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rstwait_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rvalid_resp", 32'(resp_valid), 32'd0);
      chk("late_rvalid_ready", 32'(req_ready), 32'd1);
    end
    mem_bus.mem_rvalid = 1'b0;

    // Reset while requesting: mem_req must fall without waiting for a clock.
    launch_load(32'h500);
    chk("rstreq_mem_req_before", 32'(mem_bus.mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstreq_mem_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstreq_resp_valid", 32'(resp_valid), 32'd0);

    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int g;
      int d;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      g = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, MAX_WAIT + 2);
      d = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, MAX_WAIT + 2);
      run_txn(1'($urandom), 3'($urandom), a, $urandom, $urandom, 5'($urandom), g, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
